// File: rtl/reset_sequencer_pkg.sv
// Shared constants for the staged reset sequencer: FSM encoding and default delays.
package reset_sequencer_pkg;

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_RELEASE  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_REASSERT = 2'd3;

  localparam int          DEF_CNT_W       = 24;
  localparam logic [23:0] DEF_STAGE_DELAY = 24'h008000;
  localparam logic [23:0] DEF_HOLD_CYCLES = 24'h000100;

  // Stage index width; a single-stage build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_stage_timer.sv
// Delay counter for the sequencer; clears itself on terminal count so it never wraps.
module reset_stage_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = en && (count == limit - CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset || clr || tc)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases reset domains in order after PLL lock and
// re-runs the sequence on lock loss or an arbitrated soft-reset request.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int               NUM_STAGES  = 3,
  parameter int               NUM_REQ     = 2,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] STAGE_DELAY = CNT_W'(DEF_STAGE_DELAY),
  parameter logic [CNT_W-1:0] HOLD_CYCLES = CNT_W'(DEF_HOLD_CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic [NUM_REQ-1:0]    soft_req,
  output logic [NUM_REQ-1:0]    soft_ack,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  busy,
  output logic                  ready
);

  localparam int               IDX_W    = idx_width(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic [1:0]            state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [NUM_STAGES-1:0] stage_nx;
  logic [NUM_REQ-1:0]    ack_nx, grant;
  logic                  found;
  logic                  tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0]      tmr_limit;

  assign tmr_limit = (state == ST_REASSERT) ? HOLD_CYCLES : STAGE_DELAY;

  reset_stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  // Fixed priority: lowest-index requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (soft_req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    stage_nx = stage_reset;
    ack_nx   = '0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      ST_HOLD: begin
        stage_nx = '1;
        idx_nx   = '0;
        tmr_clr  = 1'b1;
        if (pll_locked) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Lock loss outranks a stage release landing on the same edge.
        if (!pll_locked) begin
          state_nx = ST_REASSERT;
          stage_nx = '1;
          idx_nx   = '0;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (IDX_W'(i) == idx) stage_nx[i] = 1'b0;
            idx_nx = idx + IDX_W'(1);
            if (idx == LAST_IDX) state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        stage_nx = '0;
        tmr_clr  = 1'b1;
        if (!pll_locked) begin
          state_nx = ST_REASSERT;
          stage_nx = '1;
        end else if (|soft_req) begin
          state_nx = ST_REASSERT;
          stage_nx = '1;
          ack_nx   = grant;
        end
      end
      default: begin
        stage_nx = '1;
        idx_nx   = '0;
        tmr_en   = 1'b1;
        if (tmr_tc) state_nx = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_HOLD;
      idx         <= '0;
      stage_reset <= '1;
      soft_ack    <= '0;
      ready       <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      stage_reset <= stage_nx;
      soft_ack    <= ack_nx;
      ready       <= (state_nx == ST_RUN);
      busy        <= (state_nx != ST_RUN);
    end
  end

endmodule
